// File: rtl/dco_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dco_lock_ctrl
// Purpose  : Closed-loop tap controller for an 8-tap DCO. Counts synchronised
//            DCO rising edges over a fixed clk window, compares the count with
//            a target and steps the one-hot tap select until the count is
//            within tolerance.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            ena        - design enable; low forces IDLE (idx/meas/err held)
//            start      - single-cycle request to run a lock sequence
//            target_cnt - desired edge count per window
//            dco_in     - DCO output, asynchronous to clk
//            dco_code   - registered one-hot tap select (1 << idx)
//            busy       - high while settling, measuring or adjusting
//            locked     - high while holding a locked code
//            range_err  - sticky: a step beyond tap 0 or tap 7 was required
//            meas_cnt   - edge count of the last completed window
// Revision : 1.0 - initial release
// ============================================================================
module dco_lock_ctrl #(
  parameter int CW         = 8,
  parameter int WINDOW     = 256,
  parameter int SETTLE_CYC = 16,
  parameter int TOL        = 1,
  parameter int INIT_IDX   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic [CW-1:0] target_cnt,
  input  logic          dco_in,
  output logic [7:0]    dco_code,
  output logic          busy,
  output logic          locked,
  output logic          range_err,
  output logic [CW-1:0] meas_cnt
);

  // One extra bit keeps the cycle counter safe for any window/settle size.
  localparam int              c_TW          = $clog2((WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC) + 1;
  localparam logic [c_TW-1:0] c_SETTLE_LAST = c_TW'(SETTLE_CYC - 1);
  localparam logic [c_TW-1:0] c_WINDOW_LAST = c_TW'(WINDOW - 1);
  localparam logic [CW-1:0]   c_TOL         = CW'(TOL);
  localparam logic [2:0]      c_INIT_IDX    = 3'(INIT_IDX);
  localparam logic [2:0]      c_IDX_MAX     = 3'd7;
  localparam logic [7:0]      c_INIT_CODE   = 8'd1 << c_INIT_IDX;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_ADJUST  = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2, r_sync3;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [c_TW-1:0] r_cyc, w_cyc_nxt;
  logic [CW-1:0]   r_edge, w_edge_nxt;
  logic [CW-1:0]   r_meas, w_meas_nxt;
  logic            r_rerr, w_rerr_nxt;
  logic            r_dir_valid, w_dir_valid_nxt;
  logic            r_dir_up, w_dir_up_nxt;
  logic [7:0]      r_code;

  logic            w_rise;
  logic [CW-1:0]   w_edge_sum;
  logic [CW-1:0]   w_diff;
  logic            w_meas_low;

  // Rising edge seen after the two-flop synchroniser.
  assign w_rise     = r_sync2 & ~r_sync3;
  // Edge counter saturates at all-ones.
  assign w_edge_sum = (w_rise && (r_edge != '1)) ? r_edge + 1'b1 : r_edge;
  assign w_meas_low = (r_meas < target_cnt);
  assign w_diff     = w_meas_low ? (target_cnt - r_meas) : (r_meas - target_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_idx       <= c_INIT_IDX;
      r_cyc       <= '0;
      r_edge      <= '0;
      r_meas      <= '0;
      r_rerr      <= 1'b0;
      r_dir_valid <= 1'b0;
      r_dir_up    <= 1'b0;
      r_code      <= c_INIT_CODE;
    end else begin
      r_state     <= w_state_nxt;
      r_sync1     <= dco_in;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_idx       <= w_idx_nxt;
      r_cyc       <= w_cyc_nxt;
      r_edge      <= w_edge_nxt;
      r_meas      <= w_meas_nxt;
      r_rerr      <= w_rerr_nxt;
      r_dir_valid <= w_dir_valid_nxt;
      r_dir_up    <= w_dir_up_nxt;
      r_code      <= 8'd1 << w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cyc_nxt       = r_cyc;
    w_edge_nxt      = r_edge;
    w_meas_nxt      = r_meas;
    w_rerr_nxt      = r_rerr;
    w_dir_valid_nxt = r_dir_valid;
    w_dir_up_nxt    = r_dir_up;

    if (!ena) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt     = S_SETTLE;
            w_rerr_nxt      = 1'b0;
            w_dir_valid_nxt = 1'b0;
            w_cyc_nxt       = '0;
          end
        end
        S_SETTLE: begin
          if (r_cyc == c_SETTLE_LAST) begin
            w_state_nxt = S_MEASURE;
            w_cyc_nxt   = '0;
            w_edge_nxt  = '0;
          end else begin
            w_cyc_nxt = r_cyc + 1'b1;
          end
        end
        S_MEASURE: begin
          w_edge_nxt = w_edge_sum;
          if (r_cyc == c_WINDOW_LAST) begin
            w_meas_nxt  = w_edge_sum;
            w_state_nxt = S_ADJUST;
            w_cyc_nxt   = '0;
          end else begin
            w_cyc_nxt = r_cyc + 1'b1;
          end
        end
        S_ADJUST: begin
          if (w_diff <= c_TOL) begin
            w_state_nxt = S_LOCKED;
          end else if (w_meas_low) begin
            // Too slow: move to a faster tap unless that undoes a DN step.
            if (r_dir_valid && !r_dir_up) begin
              w_state_nxt = S_LOCKED;
            end else if (r_idx == c_IDX_MAX) begin
              w_rerr_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_idx_nxt       = r_idx + 3'd1;
              w_dir_valid_nxt = 1'b1;
              w_dir_up_nxt    = 1'b1;
              w_state_nxt     = S_SETTLE;
            end
          end else begin
            // Too fast: move to a slower tap unless that undoes an UP step.
            if (r_dir_valid && r_dir_up) begin
              w_state_nxt = S_LOCKED;
            end else if (r_idx == 3'd0) begin
              w_rerr_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_idx_nxt       = r_idx - 3'd1;
              w_dir_valid_nxt = 1'b1;
              w_dir_up_nxt    = 1'b0;
              w_state_nxt     = S_SETTLE;
            end
          end
        end
        S_LOCKED: begin
          // A re-lock is a fresh sequence from the held tap, so the
          // reversal history of the previous sequence is discarded.
          if (start) begin
            w_state_nxt     = S_SETTLE;
            w_dir_valid_nxt = 1'b0;
            w_cyc_nxt       = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_SETTLE) || (r_state == S_MEASURE) || (r_state == S_ADJUST);
  assign locked    = (r_state == S_LOCKED);
  assign range_err = r_rerr;
  assign meas_cnt  = r_meas;
  assign dco_code  = r_code;

endmodule
`default_nettype wire
